// File: rtl/mem_io_pkg.sv
// Shared constants for the memory/I-O slave: I/O page decode addresses,
// STATUS register bit positions and the UART transmitter state encoding.
package mem_io_pkg;

    localparam logic [7:0]  IO_PAGE   = 8'hFF;
    localparam logic [15:0] UART_DATA = 16'hFF00;
    localparam logic [15:0] UART_STAT = 16'hFF02;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/mem_io_sync_fifo.sv
// Single-clock FIFO with registered count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    // A byte pushed into an empty FIFO is never poppable in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_io.sv
// Zero-wait-state memory and I/O slave: byte-lane word RAM plus a
// memory-mapped 8N1 UART transmitter fed from a small TX FIFO.
module mem_io
    import mem_io_pkg::*;
#(
    parameter int AW           = 12,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] RAMaddr,
    input  logic [15:0] RAMin,
    input  logic        we,
    input  logic        be,
    output logic [15:0] RAMout,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    logic [AW-1:0]   word_idx;
    logic            is_io;
    logic            is_data;
    logic            is_stat;
    logic [1:0][7:0] ram_word;

    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      status;

    tx_state_t       state_reg;
    logic [BW-1:0]   baud_reg;
    logic [2:0]      bit_reg;
    logic [7:0]      shift_reg;
    logic            tx_reg;
    logic            overflow_reg;
    logic            baud_done;

    assign word_idx = RAMaddr[AW:1];
    assign is_io    = (RAMaddr[15:8] == IO_PAGE);
    assign is_data  = (RAMaddr[15:1] == UART_DATA[15:1]);
    assign is_stat  = (RAMaddr[15:1] == UART_STAT[15:1]);

    // One array per byte lane so a byte write leaves the other lane untouched.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] lane_mem [2**AW];
            logic       lane_we;
            logic [7:0] lane_din;

            assign lane_we  = we && !is_io && (!be || (RAMaddr[0] == 1'(gi)));
            assign lane_din = be ? RAMin[7:0] : RAMin[gi*8 +: 8];

            always_ff @(posedge clk) begin
                if (lane_we) begin
                    lane_mem[word_idx] <= lane_din;
                end
            end

            assign ram_word[gi] = lane_mem[word_idx];
        end
    endgenerate

    always_comb begin
        status               = '0;
        status[ST_FULL]      = fifo_full;
        status[ST_EMPTY]     = fifo_empty;
        status[ST_BUSY]      = (state_reg != IDLE);
        status[ST_OVF]       = overflow_reg;
        status[7:ST_COUNT_LSB] = 4'(fifo_count);
    end

    always_comb begin
        RAMout = '0;
        if (is_io) begin
            if (is_stat) begin
                RAMout = {8'h00, status};
            end
        end else if (be) begin
            RAMout = {8'h00, ram_word[RAMaddr[0]]};
        end else begin
            RAMout = ram_word;
        end
    end

    assign fifo_push = we && is_data;
    assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (RAMin[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (we && is_stat) begin
            overflow_reg <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign baud_done = (baud_reg == BW'(CLKS_PER_BIT - 1));
    assign tx        = tx_reg;

    // tx is registered from the current state, so the line trails the FSM by
    // one clock; every bit therefore still lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            if (state_reg != IDLE) begin
                baud_reg <= baud_done ? '0 : baud_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_dout;
                        baud_reg  <= '0;
                        bit_reg   <= '0;
                        state_reg <= START;
                    end
                end
                START: begin
                    tx_reg <= 1'b0;
                    if (baud_done) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    tx_reg <= shift_reg[bit_reg];
                    if (baud_done) begin
                        bit_reg <= bit_reg + 1'b1;
                        if (bit_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (baud_done) begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io.sv
// Scoreboard bench for mem_io: reads and UART frames are checked against a
// byte-array RAM model and a queue of bytes expected on the serial line.
module tb_mem_io;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] RAMaddr;
    logic [15:0] RAMin;
    logic        we;
    logic        be;
    logic [15:0] RAMout;
    logic        tx;

    always #5 clk = ~clk;

    mem_io #(
        .AW           (4),
        .FIFO_DEPTH   (8),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .RAMaddr (RAMaddr),
        .RAMin   (RAMin),
        .we      (we),
        .be      (be),
        .RAMout  (RAMout),
        .tx      (tx)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rd_exp_q [$];
    string       rd_name_q [$];
    logic        rd_strobe = 1'b0;
    logic [7:0]  tx_exp_q [$];

    logic [7:0]  mem_model [32];
    bit          mem_known [32];

    // Read monitor: one expected value is queued per read strobe.
    always @(negedge clk) begin
        logic [15:0] e;
        string       nm;
        if (rd_strobe && rd_exp_q.size() > 0) begin
            e  = rd_exp_q.pop_front();
            nm = rd_name_q.pop_front();
            n_cmp++;
            if (RAMout !== e) begin
                n_fail++;
                $display("FAIL %s: addr=%h be=%b RAMout=%h expected %h", nm, RAMaddr, be, RAMout, e);
            end else begin
                $display("ok   %s: addr=%h be=%b RAMout=%h", nm, RAMaddr, be, RAMout);
            end
        end
    end

    // Serial monitor: decode each 8N1 frame and compare with the next queued byte.
    initial begin
        logic [9:0] bits;
        bit         ok;
        bit         aborted;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || tx !== 1'b0) continue;
            bits    = '0;
            ok      = 1'b1;
            aborted = 1'b0;
            for (int b = 0; b < 10; b++) begin
                for (int s = 0; s < C; s++) begin
                    if (b != 0 || s != 0) @(negedge clk);
                    if (reset !== 1'b0) aborted = 1'b1;
                    if (s == 0) bits[b] = tx;
                    else if (tx !== bits[b]) ok = 1'b0;
                end
            end
            if (aborted) continue;
            n_cmp++;
            if (!ok || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                n_fail++;
                $display("FAIL frame_shape: line bits=%b steady=%0d, required start 0, stop 1, steady bits", bits, ok);
            end
            n_cmp++;
            if (tx_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame: got byte %h, required no frame", bits[8:1]);
            end else begin
                e = tx_exp_q.pop_front();
                if (bits[8:1] !== e) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %h expected %h", bits[8:1], e);
                end else begin
                    $display("ok   tx_byte: %h", bits[8:1]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    function automatic int midx(input logic [15:0] a, input int lane);
        return (int'(a >> 1) % 16) * 2 + lane;
    endfunction

    task automatic model_wr(input logic [15:0] a, input logic [15:0] d, input logic b);
        if (a[15:8] == 8'hFF) return;
        if (b) begin
            mem_model[midx(a, int'(a[0]))] = d[7:0];
            mem_known[midx(a, int'(a[0]))] = 1'b1;
        end else begin
            mem_model[midx(a, 0)] = d[7:0];
            mem_model[midx(a, 1)] = d[15:8];
            mem_known[midx(a, 0)] = 1'b1;
            mem_known[midx(a, 1)] = 1'b1;
        end
    endtask

    task automatic model_rd(input logic [15:0] a, input logic b, output logic [15:0] e, output bit ok);
        if (b) begin
            e  = {8'h00, mem_model[midx(a, int'(a[0]))]};
            ok = mem_known[midx(a, int'(a[0]))];
        end else begin
            e  = {mem_model[midx(a, 1)], mem_model[midx(a, 0)]};
            ok = mem_known[midx(a, 0)] && mem_known[midx(a, 1)];
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic b);
        RAMaddr = a;
        RAMin   = d;
        be      = b;
        we      = 1'b1;
        model_wr(a, d, b);
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic b, input logic [15:0] e, input string nm);
        RAMaddr = a;
        be      = b;
        we      = 1'b0;
        rd_exp_q.push_back(e);
        rd_name_q.push_back(nm);
        rd_strobe = 1'b1;
        step();
        rd_strobe = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit expect_sent);
        wr(16'hFF00, {8'h00, d}, 1'b0);
        if (expect_sent) tx_exp_q.push_back(d);
    endtask

    task automatic wait_fall(output int f);
        f = -1;
        for (int k = 0; k < 400; k++) begin
            if (tx === 1'b0) begin
                f = cyc;
                return;
            end
            step();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_fall: tx stayed %b, required a start bit within 400 cycles", tx);
    endtask

    initial begin
        int          f;
        logic [7:0]  d;
        logic [15:0] a;
        logic [15:0] e;
        logic        b;
        bit          ok;

        reset   = 1'b1;
        we      = 1'b0;
        be      = 1'b0;
        RAMaddr = '0;
        RAMin   = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_tx", {15'd0, tx}, 16'h0001);
        rd(16'hFF02, 1'b0, 16'h0002, "reset_status");

        // Directed RAM word/byte access and mirroring (16-word RAM)
        wr(16'h0010, 16'hBEEF, 1'b0);
        rd(16'h0010, 1'b0, 16'hBEEF, "word_rd");
        wr(16'h0011, 16'h0012, 1'b1);
        rd(16'h0010, 1'b0, 16'h12EF, "byte_wr_hi");
        rd(16'h0010, 1'b1, 16'h00EF, "byte_rd_lo");
        rd(16'h0011, 1'b1, 16'h0012, "byte_rd_hi");
        wr(16'h0002, 16'h1234, 1'b0);
        rd(16'h0022, 1'b0, 16'h1234, "mirror");
        wr(16'h0006, 16'h5555, 1'b0);
        wr(16'hFF06, 16'hFFFF, 1'b0);
        rd(16'h0006, 1'b0, 16'h5555, "io_write_no_ram");
        rd(16'hFF00, 1'b0, 16'h0000, "data_rd_zero");
        rd(16'hFF04, 1'b0, 16'h0000, "other_io_zero");
        rd(16'hFF03, 1'b1, 16'h0002, "status_be_ignored");

        // Single frame: start bit appears two cycles after the push edge
        push_byte(8'hA5, 1'b1);
        chk("tx_after_push", {15'd0, tx}, 16'h0001);
        step();
        chk("tx_after_pop", {15'd0, tx}, 16'h0001);
        step();
        chk("tx_start_bit", {15'd0, tx}, 16'h0000);
        repeat (10 * C + 2) step();
        rd(16'hFF02, 1'b0, 16'h0002, "frame_done_status");

        // Overflow: 9 pushes while a frame is on the line, the 9th dropped
        push_byte(8'h3C, 1'b1);
        wait_fall(f);
        for (int i = 1; i <= 9; i++) begin
            d = 8'($urandom);
            push_byte(d, i <= 8);
        end
        rd(16'hFF02, 1'b0, 16'h008D, "overflow_status");
        wr(16'hFF02, 16'($urandom), 1'b0);
        rd(16'hFF02, 1'b0, 16'h0085, "overflow_cleared");

        // Push on the exact edge the idle state pops from the full FIFO
        while (f >= 0 && cyc < f + 10 * C - 1) step();
        push_byte(8'($urandom), 1'b1);
        rd(16'hFF02, 1'b0, 16'h0085, "push_with_pop_full");
        repeat (9 * (10 * C + 1) + 10) step();
        rd(16'hFF02, 1'b0, 16'h0002, "drained_status");
        chk("frames_outstanding", 16'(tx_exp_q.size()), 16'h0000);

        // Random back-to-back frames
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1'b1);
        repeat (3 * (10 * C + 1) + 10) step();
        rd(16'hFF02, 1'b0, 16'h0002, "rand_frames_status");
        chk("rand_frames_outstanding", 16'(tx_exp_q.size()), 16'h0000);

        // Reset in the middle of the data bits discards frame and FIFO
        push_byte(8'h81, 1'b0);
        push_byte(8'h7E, 1'b0);
        push_byte(8'h42, 1'b0);
        wait_fall(f);
        while (f >= 0 && cyc < f + 3 * C) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_mid_tx", {15'd0, tx}, 16'h0001);
        rd(16'hFF02, 1'b0, 16'h0002, "reset_mid_status");
        model_rd(16'h0010, 1'b0, e, ok);
        rd(16'h0010, 1'b0, e, "ram_kept_after_reset");
        repeat (10 * C + 10) step();

        // Random RAM traffic against the byte-array model
        for (int i = 0; i < 80; i++) begin
            a = 16'($urandom_range(0, 32'hFEFF));
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                wr(a, 16'($urandom), b);
            end else begin
                model_rd(a, b, e, ok);
                if (ok) rd(a, b, e, "rand_rd");
            end
        end

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io.md
# mem_io

Memory and I/O slave directly downstream of `cpu`: consumes its `RAMaddr`/`RAMin`/`we`/`be` bus and produces `RAMout`. It holds the main 16-bit word RAM with byte-lane writes and a memory-mapped 8N1 UART transmitter with an 8-entry TX FIFO. `cpu` has no stall input, so every access completes without wait states.

## Interface

Parameters:
- `AW`, 12: RAM word-address width (2^AW words).
- `FIFO_DEPTH`, 8: TX FIFO entries (power of two).
- `CLKS_PER_BIT`, 434: clocks per UART bit (≥2).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `RAMaddr`  in  16: byte address from `cpu` MAR.
- `RAMin`  in  16: write data from `cpu` MDR.
- `we`  in  1: write strobe, sampled at rising edge.
- `be`  in  1: 1 = byte access, 0 = word access.
- `RAMout`  out  16: read data, combinational from `RAMaddr`/`be`.
- `tx`  out  1: UART serial out, idle high.

## Operation

- Map:
  - `RAMaddr[15:8]==8'hFF` is the I/O page.
  - Any other address is RAM word `RAMaddr[AW:1]`; RAM mirrors modulo 2^AW words.
- RAM read:
  - `be=0`: full word; `RAMaddr[0]` ignored.
  - `be=1`: selected byte zero-extended; `RAMaddr[0]=0` selects the low byte, `1` the high byte.
- RAM write (`we=1`):
  - `be=0`: writes the whole word.
  - `be=1`: writes `RAMin[7:0]` into the lane selected by `RAMaddr[0]`; the other lane is unchanged.
  - RAM contents are not reset.
- I/O decode uses `RAMaddr[15:1]`; `be` does not affect I/O behaviour.
- `16'hFF00` DATA:
  - Write pushes `RAMin[7:0]` into the FIFO.
  - Read returns `16'h0000`.
- `16'hFF02` STATUS (read):
  - bit0 full, bit1 empty, bit2 tx busy (state≠IDLE), bit3 overflow (sticky).
  - bits[7:4] FIFO count (0..8); upper bits 0.
  - Reads have no side effects.
- STATUS write with any data clears overflow.
- Other I/O addresses read `16'h0000`; writes to them are ignored.
- FIFO push when full:
  - Dropped and overflow set, unless a pop occurs in the same cycle; then the push is accepted.
  - Empty + push: the byte cannot be popped in that cycle.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop into the shift register, clear the baud counter, go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each, bit counter 0..7, then STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles, then IDLE.
  - `tx` is registered.

## Timing

- Reset values:
  - `tx=1`, state IDLE, FIFO empty (count 0), overflow 0, baud and bit counters 0.
  - `RAMout` follows the current address after reset.
- Read latency 0: `RAMout` is valid in the same cycle `RAMaddr` is stable.
- Writes take effect at the edge where `we=1`; a read of the same address in the next cycle sees new data.
- Push to an idle, empty block on edge N:
  - Pop and transition to START on edge N+1.
  - `tx` falls after edge N+2.
- Frame is exactly 10·CLKS_PER_BIT cycles of `tx` low/data/high.
- Back-to-back frames: exactly one extra idle-high cycle (the IDLE pop cycle) between the STOP end and the next start bit.
- Count is updated at the same edge as the push/pop. STATUS reflects the registered values.
- Reset mid-frame:
  - Aborts the frame; `tx=1` from the edge where reset is sampled.
  - FIFO contents are discarded.

## Structure

- Package `mem_io_pkg`:
  - `IO_PAGE=8'hFF`, `UART_DATA=16'hFF00`, `UART_STAT=16'hFF02`.
  - Status bit indices.
  - TX state enum (IDLE, START, DATA, STOP).
- Sub-module `sync_fifo`, parameterised by width/depth:
  - Ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - Implements the simultaneous push/pop-when-full rule.
- RAM, address decode, read mux and TX FSM live in `mem_io`.

## Test plan

- RAM word and byte access:
  - Word write `16'hBEEF` to `16'h0010`; word read gives `16'hBEEF`.
  - Byte write `8'h12` at `16'h0011`; word read gives `16'h12EF`.
  - Byte read at `16'h0010` gives `16'h00EF`.
- Mirroring: with `AW=4`, word write `16'h1234` at `16'h0002`; read at `16'h0022` gives `16'h1234`.
- Single frame: with `CLKS_PER_BIT=4`, write `16'h00A5` to `16'hFF00`.
  - `tx` falls 2 cycles later.
  - Line then carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - STATUS returns to `16'h0002`.
- FIFO full/overflow:
  - 9 pushes while a frame is in progress: STATUS shows count 8, full=1, overflow=1, and the 9th byte is never transmitted.
  - A write to STATUS clears overflow.
- Push-when-full with simultaneous pop: push on the exact cycle IDLE pops from a full FIFO; the byte is accepted and count stays 8.
- Reset mid-DATA:
  - Assert `reset` one cycle; `tx=1` next cycle and STATUS reads `16'h0002`.
  - RAM contents written earlier are still readable.
